// File: rtl/ioctl_rom_router_if.sv
// Toggle req/ack write-port bundle between the ROM router and the memory
// controller, one request/ack pair per destination region.
interface ioctl_rom_router_if #(
  parameter int NREG = 2,
  parameter int WB   = 2,
  parameter int AW   = 24
);
  logic [NREG-1:0]      port_req;
  logic [NREG-1:0]      port_ack;
  logic [NREG*AW-1:0]   port_a;
  logic [NREG*WB-1:0]   port_ds;
  logic [NREG*8*WB-1:0] port_d;
  logic [NREG-1:0]      port_we;

  modport master (
    output port_req, port_a, port_ds, port_d, port_we,
    input  port_ack
  );

  modport slave (
    input  port_req, port_a, port_ds, port_d, port_we,
    output port_ack
  );
endinterface

// File: rtl/ioctl_rom_router.sv
// Routes the byte-serial ioctl ROM download into NREG toggle req/ack write
// ports, packing bytes into WB-byte words and flagging completion.
module ioctl_rom_router #(
  parameter int                 NREG        = 2,
  parameter int                 WB          = 2,
  parameter int                 AW          = 24,
  parameter logic [7:0]         ROM_INDEX   = 8'd0,
  parameter logic [NREG*25-1:0] REGION_BASE = {25'h0E000, 25'h0},
  parameter logic [24:0]        REGION_TOP  = 25'h1FFFFFF
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic                      ioctl_downl,
  input  logic [7:0]                ioctl_index,
  input  logic                      ioctl_wr,
  input  logic [24:0]               ioctl_addr,
  input  logic [7:0]                ioctl_dout,
  output logic                      ioctl_wait,
  ioctl_rom_router_if.master        mem,
  output logic                      rom_loaded,
  output logic                      overflow
);

  localparam int LB = $clog2(WB);
  localparam int LW = (LB > 0) ? LB : 1;
  localparam int KW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int OW = (AW + LB > 25) ? AW + LB : 25;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t            state;
  logic              wr_q, act_q, loading, end_pend;
  logic [NREG-1:0]   ack_q;
  logic              buf_v;
  logic [KW-1:0]     buf_k;
  logic [AW-1:0]     buf_word;
  logic [8*WB-1:0]   buf_d;
  logic [WB-1:0]     buf_ds;
  logic              pend_v, pend_last;
  logic [KW-1:0]     pend_k;
  logic [AW-1:0]     pend_word;
  logic [8*WB-1:0]   pend_d;
  logic [WB-1:0]     pend_ds;

  logic              act, act_rise, act_fall, wr_rise, accept, port_free, end_now;
  logic              dec_ovf, dec_same, dec_last;
  logic [KW-1:0]     dec_k;
  logic [24:0]       dec_base;
  logic [OW-1:0]     dec_off;
  logic [AW-1:0]     dec_word;
  logic [LW-1:0]     dec_lane;
  logic [8*WB-1:0]   dec_dword;
  logic [WB-1:0]     dec_dsw;

  assign act       = ioctl_downl && (ioctl_index == ROM_INDEX);
  assign act_rise  = act & ~act_q;
  assign act_fall  = act_q & ~act;
  assign wr_rise   = ioctl_wr & ~wr_q;
  assign end_now   = end_pend | act_fall;
  assign port_free = (mem.port_req[buf_k] == ack_q[buf_k]);
  // A pending byte from a region/word change also stalls the loader until it is buffered.
  assign ioctl_wait = (state == S_DRAIN) || ((state == S_ISSUE) && (!port_free || pend_v));
  assign accept    = wr_rise && act && !ioctl_wait && ((state == S_IDLE) || (state == S_ISSUE));

  always_comb begin
    dec_k    = '0;
    dec_base = REGION_BASE[24:0];
    for (int unsigned i = 1; i < NREG; i++) begin
      if (ioctl_addr >= REGION_BASE[i*25 +: 25]) begin
        dec_k    = KW'(i);
        dec_base = REGION_BASE[i*25 +: 25];
      end
    end
    dec_ovf   = (ioctl_addr >= REGION_TOP) || (ioctl_addr < REGION_BASE[24:0]);
    dec_off   = OW'(ioctl_addr - dec_base);
    dec_word  = dec_off[LB +: AW];
    dec_lane  = LW'(dec_off % OW'(WB));
    dec_last  = (int'(dec_lane) == WB - 1);
    dec_dword = '0;
    dec_dword[dec_lane*8 +: 8] = ioctl_dout;
    dec_dsw   = '0;
    dec_dsw[dec_lane] = 1'b1;
    dec_same  = buf_v && (dec_k == buf_k) && (dec_word == buf_word);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state        <= S_IDLE;
      wr_q         <= 1'b0;
      act_q        <= 1'b0;
      ack_q        <= '0;
      loading      <= 1'b0;
      end_pend     <= 1'b0;
      buf_v        <= 1'b0;
      buf_k        <= '0;
      buf_word     <= '0;
      buf_d        <= '0;
      buf_ds       <= '0;
      pend_v       <= 1'b0;
      pend_last    <= 1'b0;
      pend_k       <= '0;
      pend_word    <= '0;
      pend_d       <= '0;
      pend_ds      <= '0;
      mem.port_req <= '0;
      mem.port_a   <= '0;
      mem.port_ds  <= '0;
      mem.port_d   <= '0;
      mem.port_we  <= '0;
      rom_loaded   <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      wr_q        <= ioctl_wr;
      act_q       <= act;
      ack_q       <= mem.port_ack;
      mem.port_we <= {NREG{loading}};
      if (act) loading <= 1'b1;
      if (accept && dec_ovf) overflow <= 1'b1;

      case (state)
        S_IDLE: begin
          if (accept && !dec_ovf) begin
            if (!buf_v || dec_same) begin
              buf_v    <= 1'b1;
              buf_k    <= dec_k;
              buf_word <= dec_word;
              buf_d[dec_lane*8 +: 8] <= ioctl_dout;
              buf_ds[dec_lane]       <= 1'b1;
              if (dec_last) state <= S_ISSUE;
            end else begin
              pend_v    <= 1'b1;
              pend_k    <= dec_k;
              pend_word <= dec_word;
              pend_d    <= dec_dword;
              pend_ds   <= dec_dsw;
              pend_last <= dec_last;
              state     <= S_ISSUE;
            end
          end else if (act_fall) begin
            if (buf_v) begin
              end_pend <= 1'b1;
              state    <= S_ISSUE;
            end else begin
              state <= S_DRAIN;
            end
          end
        end

        S_ISSUE: begin
          if (port_free) begin
            mem.port_req[buf_k]             <= ~mem.port_req[buf_k];
            mem.port_a[buf_k*AW +: AW]      <= buf_word;
            mem.port_ds[buf_k*WB +: WB]     <= buf_ds;
            mem.port_d[buf_k*8*WB +: 8*WB]  <= buf_d;
            // The freed buffer is refilled by the stalled byte, or by a fresh strobe.
            if (pend_v) begin
              pend_v   <= 1'b0;
              buf_k    <= pend_k;
              buf_word <= pend_word;
              buf_d    <= pend_d;
              buf_ds   <= pend_ds;
              end_pend <= end_now;
              state    <= (pend_last || end_now) ? S_ISSUE : S_IDLE;
            end else if (accept && !dec_ovf) begin
              buf_k    <= dec_k;
              buf_word <= dec_word;
              buf_d    <= dec_dword;
              buf_ds   <= dec_dsw;
              state    <= dec_last ? S_ISSUE : S_IDLE;
            end else begin
              buf_v    <= 1'b0;
              buf_d    <= '0;
              buf_ds   <= '0;
              end_pend <= 1'b0;
              state    <= end_now ? S_DRAIN : S_IDLE;
            end
          end else if (act_fall) begin
            end_pend <= 1'b1;
          end
        end

        S_DRAIN: begin
          if (mem.port_req == ack_q) begin
            state      <= S_DONE;
            rom_loaded <= 1'b1;
            loading    <= 1'b0;
          end
        end

        S_DONE: begin
          if (act_rise) begin
            state      <= S_IDLE;
            rom_loaded <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ioctl_rom_router.sv
// Directed bench for ioctl_rom_router with a toggle-ack memory responder
// that records every acknowledged write into a byte image.
module tb_ioctl_rom_router;

  typedef struct {
    int          p;
    logic [23:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } wr_t;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_downl;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        rom_loaded;
  logic        overflow;
  logic [1:0]  ack;
  logic [1:0]  hold;

  int checks = 0;
  int errors = 0;
  wr_t log_q[$];
  logic [7:0] img [int];

  ioctl_rom_router_if #(.NREG(2), .WB(2), .AW(24)) bus ();
  assign bus.port_ack = ack;

  ioctl_rom_router #(
    .NREG(2), .WB(2), .AW(24), .ROM_INDEX(8'd0),
    .REGION_BASE({25'h0E000, 25'h0}), .REGION_TOP(25'h1FFFFFF)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_downl(ioctl_downl),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .mem(bus),
    .rom_loaded(rom_loaded), .overflow(overflow)
  );

  initial forever #5 clk_sys = ~clk_sys;

  // Memory side: acknowledge each request on the following falling edge unless held.
  initial begin
    ack = '0;
    forever begin
      @(negedge clk_sys);
      if (reset) ack = '0;
      else begin
        for (int p = 0; p < 2; p++) begin
          if (bus.port_req[p] !== ack[p] && !hold[p]) begin
            wr_t w;
            w.p  = p;
            w.a  = bus.port_a[p*24 +: 24];
            w.ds = bus.port_ds[p*2 +: 2];
            w.d  = bus.port_d[p*16 +: 16];
            log_q.push_back(w);
            for (int l = 0; l < 2; l++)
              if (w.ds[l]) img[p*32'h4000000 + int'(w.a)*2 + l] = w.d[l*8 +: 8];
            ack[p] = ~ack[p];
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk_sys); #1; end
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    int n = 0;
    while (ioctl_wait && n < 200) begin tick(1); n++; end
    if (ioctl_wait) begin
      checks++; errors++;
      $display("FAIL send_wait_timeout: ioctl_wait still %b, required 0", ioctl_wait);
    end
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick(2);
    ioctl_wr   = 1'b0;
    tick(1);
  endtask

  task automatic wait_loaded(input string name);
    int n = 0;
    while (rom_loaded !== 1'b1 && n < 100) begin tick(1); n++; end
    checks++;
    if (rom_loaded !== 1'b1) begin
      errors++;
      $display("FAIL %s_rom_loaded: got %b, required 1", name, rom_loaded);
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({ioctl_wait, rom_loaded, overflow} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b, required 000", {ioctl_wait, rom_loaded, overflow});
    end
    checks++;
    if ({bus.port_req, bus.port_we} !== 4'h0) begin
      errors++; $display("FAIL reset_req_we: got %h, required 0", {bus.port_req, bus.port_we});
    end
    checks++;
    if (bus.port_a !== 48'h0 || bus.port_ds !== 4'h0) begin
      errors++; $display("FAIL reset_a_ds: got %h/%h, required 0/0", bus.port_a, bus.port_ds);
    end
    checks++;
    if (bus.port_d !== 32'h0) begin
      errors++; $display("FAIL reset_d: got %h, required 0", bus.port_d);
    end
  endtask

  task automatic test_word_issue;
    ioctl_index = 8'd0;
    ioctl_downl = 1'b1;
    tick(2);
    send_byte(25'h0000000, 8'h11);
    ioctl_addr = 25'h0000001;
    ioctl_dout = 8'h22;
    ioctl_wr   = 1'b1;
    tick(1);
    checks++;
    if (bus.port_req !== 2'b00) begin
      errors++; $display("FAIL latency_t1: port_req got %b, required 00", bus.port_req);
    end
    tick(1);
    checks++;
    if (bus.port_req !== 2'b01) begin
      errors++; $display("FAIL latency_t2: port_req got %b, required 01", bus.port_req);
    end
    ioctl_wr = 1'b0;
    tick(3);
    checks++;
    if (bus.port_a[23:0] !== 24'h0 || bus.port_ds[1:0] !== 2'b11) begin
      errors++; $display("FAIL word0_a_ds: got %h/%b, required 0/11", bus.port_a[23:0], bus.port_ds[1:0]);
    end
    checks++;
    if (bus.port_d[15:0] !== 16'h2211) begin
      errors++; $display("FAIL word0_d: got %h, required 2211", bus.port_d[15:0]);
    end
    checks++;
    if (bus.port_req !== 2'b01 || log_q.size() != 1) begin
      errors++; $display("FAIL word0_count: req %b writes %0d, required 01 and 1", bus.port_req, log_q.size());
    end
    checks++;
    if (bus.port_we !== 2'b11) begin
      errors++; $display("FAIL word0_we: got %b, required 11", bus.port_we);
    end
  endtask

  task automatic test_partial_flush;
    log_q.delete();
    hold[1] = 1'b1;
    send_byte(25'h000E003, 8'hAB);
    ioctl_downl = 1'b0;
    tick(5);
    checks++;
    if (rom_loaded !== 1'b0 || ioctl_wait !== 1'b1) begin
      errors++; $display("FAIL drain_hold: loaded %b wait %b, required 0 and 1", rom_loaded, ioctl_wait);
    end
    checks++;
    if (bus.port_a[47:24] !== 24'h1 || bus.port_ds[3:2] !== 2'b10) begin
      errors++; $display("FAIL flush_a_ds: got %h/%b, required 1/10", bus.port_a[47:24], bus.port_ds[3:2]);
    end
    checks++;
    if (bus.port_d[31:16] !== 16'hAB00) begin
      errors++; $display("FAIL flush_d: got %h, required AB00", bus.port_d[31:16]);
    end
    hold[1] = 1'b0;
    wait_loaded("flush");
    checks++;
    if (log_q.size() != 1 || log_q[0].p != 1) begin
      errors++; $display("FAIL flush_log: writes %0d, required one write on port 1", log_q.size());
    end
  endtask

  task automatic test_stall_burst;
    int bad = 0;
    logic req_first;
    ioctl_downl = 1'b1;
    tick(2);
    checks++;
    if (rom_loaded !== 1'b0) begin
      errors++; $display("FAIL restart_loaded: got %b, required 0", rom_loaded);
    end
    log_q.delete();
    img.delete();
    hold[0] = 1'b1;
    for (int i = 0; i < 4; i++) send_byte(25'h100 + 25'(i), 8'(i*7 + 3));
    req_first = bus.port_req[0];
    for (int i = 0; i < 20; i++) begin
      if (ioctl_wait !== 1'b1) bad++;
      tick(1);
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL stall_wait: low on %0d of 20 cycles, required 0", bad);
    end
    hold[0] = 1'b0;
    @(negedge clk_sys); #1;
    tick(1);
    checks++;
    if (bus.port_req[0] !== req_first) begin
      errors++; $display("FAIL stall_ack_t1: req %b, required %b", bus.port_req[0], req_first);
    end
    tick(1);
    checks++;
    if (bus.port_req[0] !== ~req_first) begin
      errors++; $display("FAIL stall_ack_t2: req %b, required %b", bus.port_req[0], ~req_first);
    end
    for (int i = 4; i < 64; i++) send_byte(25'h100 + 25'(i), 8'(i*7 + 3));
    ioctl_downl = 1'b0;
    wait_loaded("burst");
    bad = 0;
    for (int i = 0; i < 64; i++)
      if (!img.exists(32'h100 + i) || img[32'h100 + i] !== 8'(i*7 + 3)) bad++;
    checks++;
    if (bad != 0 || log_q.size() != 32) begin
      errors++; $display("FAIL burst_image: %0d bad bytes, %0d writes, required 0 and 32", bad, log_q.size());
    end
  endtask

  task automatic test_nonseq;
    ioctl_downl = 1'b1;
    tick(2);
    log_q.delete();
    send_byte(25'h0000004, 8'h44);
    send_byte(25'h0000010, 8'h99);
    tick(2);
    checks++;
    if (log_q.size() != 1 || log_q[0].a !== 24'h2 || log_q[0].ds !== 2'b01 || log_q[0].d !== 16'h0044) begin
      errors++; $display("FAIL nonseq_first: writes %0d, required one write a=2 ds=01 d=0044", log_q.size());
    end
    ioctl_downl = 1'b0;
    wait_loaded("nonseq");
    checks++;
    if (log_q.size() != 2 || log_q[1].a !== 24'h8 || log_q[1].ds !== 2'b01 || log_q[1].d !== 16'h0099) begin
      errors++; $display("FAIL nonseq_second: writes %0d, required second write a=8 ds=01 d=0099", log_q.size());
    end
  endtask

  task automatic test_index_overflow;
    logic [1:0] req_before;
    req_before = bus.port_req;
    log_q.delete();
    ioctl_index = 8'd1;
    ioctl_downl = 1'b1;
    tick(2);
    send_byte(25'h0000000, 8'h10);
    send_byte(25'h0000001, 8'h20);
    ioctl_downl = 1'b0;
    tick(4);
    checks++;
    if (bus.port_req !== req_before || log_q.size() != 0) begin
      errors++; $display("FAIL index_ignored: req %b writes %0d, required %b and 0", bus.port_req, log_q.size(), req_before);
    end
    checks++;
    if (rom_loaded !== 1'b1) begin
      errors++; $display("FAIL index_loaded: got %b, required 1", rom_loaded);
    end
    ioctl_index = 8'd0;
    ioctl_downl = 1'b1;
    tick(2);
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL overflow_pre: got %b, required 0", overflow);
    end
    send_byte(25'h1FFFFFF, 8'h5A);
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL overflow_set: got %b, required 1", overflow);
    end
    ioctl_downl = 1'b0;
    wait_loaded("overflow");
    checks++;
    if (log_q.size() != 0 || overflow !== 1'b1) begin
      errors++; $display("FAIL overflow_nowrite: writes %0d overflow %b, required 0 and 1", log_q.size(), overflow);
    end
  endtask

  task automatic test_reset_midword;
    ioctl_downl = 1'b1;
    tick(2);
    send_byte(25'h0000020, 8'h55);
    reset = 1'b1;
    ioctl_downl = 1'b0;
    tick(1);
    test_reset();
    reset = 1'b0;
    tick(2);
    log_q.delete();
    ioctl_downl = 1'b1;
    tick(2);
    send_byte(25'h0000030, 8'h66);
    send_byte(25'h0000031, 8'h77);
    ioctl_downl = 1'b0;
    wait_loaded("after_reset");
    checks++;
    if (log_q.size() != 1 || log_q[0].a !== 24'h18 || log_q[0].ds !== 2'b11 || log_q[0].d !== 16'h7766) begin
      errors++; $display("FAIL after_reset_write: writes %0d, required one write a=18 ds=11 d=7766", log_q.size());
    end
  endtask

  initial begin
    reset       = 1'b1;
    hold        = '0;
    ioctl_downl = 1'b0;
    ioctl_index = 8'd0;
    ioctl_wr    = 1'b0;
    ioctl_addr  = '0;
    ioctl_dout  = '0;
    tick(3);
    test_reset();
    reset = 1'b0;
    tick(2);
    test_word_issue();
    test_partial_flush();
    test_stall_burst();
    test_nonseq();
    test_index_overflow();
    test_reset_midword();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
